param_1x2_demux_reg: RTL
========================

Name: param_1x2_demux_reg

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshakes. It is the counterpart of the 2-to-1 selector used throughout the datapath.
- It routes one n-bit stream to one of two consumers, chosen per transfer by sel. Typical use: CPU store/write-back path steering data to data memory (port 1) or the I/O register block (port 2).
- Each output has its own one-entry holding register, so a stalled consumer never corrupts the other path.
- Per-output transfer counters support debug and performance monitoring.

Parameters:
- n, 32, data width in bits.
- CNT_W, 16, width of each per-output transfer counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  n  input data word.
- in_sel  input  1  destination select: 0 routes to out1, 1 routes to out2.
- in_valid  input  1  in_data/in_sel are valid this cycle.
- in_ready  output  1  block accepts the input this cycle.
- out1_data  output  n  port-1 data.
- out1_valid  output  1  port-1 data valid.
- out1_ready  input  1  port-1 consumer accepts.
- out2_data  output  n  port-2 data.
- out2_valid  output  1  port-2 data valid.
- out2_ready  input  1  port-2 consumer accepts.
- out1_count  output  CNT_W  completed port-1 transfers.
- out2_count  output  CNT_W  completed port-2 transfers.

Behaviour:
- Reset (rst_n low, asynchronous): out1_valid=0, out2_valid=0, out1_data=0, out2_data=0, out1_count=0, out2_count=0.
  - Data accepted or in flight is discarded.
  - Release is synchronous to the next clk edge after rst_n rises.
- Each output k has a one-slot register holding valid_k and data_k. The outputs are driven directly from these registers, with no combinational path from in_* to out*_data or out*_valid.
- in_ready is combinational:
  - in_sel=0: in_ready = !out1_valid | out1_ready.
  - in_sel=1: in_ready = !out2_valid | out2_ready.
  - in_ready depends only on the slot selected by in_sel. The unselected slot's state is irrelevant.
- Input accept: in_valid & in_ready. On accept, slot[in_sel] loads in_data and sets valid at the next edge. Latency is 1 cycle from accept to outk_valid.
- Output drain: outk_valid & outk_ready. On drain, valid_k clears at the next edge unless a load to slot k happens in the same cycle.
- Simultaneous drain and load on the same slot: valid_k stays 1 and data_k takes the new word. This sustains full throughput of 1 word/cycle per port.
- Simultaneous load of slot A and drain of slot B (A≠B): both take effect independently.
- Stall: while outk_valid=1 and outk_ready=0, outk_data is held stable and valid_k stays 1. An input selecting k is back-pressured (in_ready=0). An input selecting the other port proceeds normally.
- Counter: outk_count increments by 1 on each drain of port k. It wraps from 2^CNT_W-1 to 0 with no flag and no saturation.
- The block never reorders words within a port and never duplicates or drops an accepted word.
- Inputs are ignored when in_valid=0; in_data/in_sel may be X at those times.

Decomposition:
- Shared package: CNT_W default, port-index constants (SEL_PORT1=0, SEL_PORT2=1).
- One natural sub-module: hs_slot_reg. It is a one-entry valid/ready register with load, drain and ready-out logic plus a transfer counter. It is instantiated twice; the top level holds only the select/in_ready steering.

Test Plan:
- Reset: hold rst_n=0, drive in_valid=1, in_sel=0, in_data=32'hDEADBEEF -> out1_valid=out2_valid=0, counts=0. Assert rst_n mid-transfer -> valids clear immediately without waiting for a clk edge.
- Basic routing, both ready=1: send 0x11 with sel=0, then 0x22 with sel=1 -> out1_data=0x11 valid one cycle later, then out2_data=0x22. out1_count=1, out2_count=1.
- Back-pressure isolation: out1_ready=0 with 0xA5 held in slot 1. in_sel=0 -> in_ready=0 and 0xA5 stable. Switch to in_sel=1 with 0x5A -> accepted and appears on out2.
- Streaming throughput: out1_ready=1, 8 back-to-back words 1..8 with sel=0 -> in_ready=1 every cycle, out1 shows 1..8 on consecutive cycles, out1_count=8.
- Same-cycle drain and load: slot 2 holds 0x33, out2_ready=1, input 0x44 with sel=1 in the same cycle -> out2_valid stays 1, next out2_data=0x44, no bubble.
- Counter wrap with CNT_W=4: complete 17 port-1 transfers -> out1_count goes 15 then 0, ending at 1.

Source files
------------

// File: rtl/param_1x2_demux_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : param_1x2_demux_reg_pkg
// Brief    : Shared constants for the registered 1-to-2 demultiplexer.
// Revision : 1.0
// ============================================================================
package param_1x2_demux_reg_pkg;

  localparam int   CNT_W_DEFAULT = 16;
  localparam logic SEL_PORT1     = 1'b0;
  localparam logic SEL_PORT2     = 1'b1;

endpackage : param_1x2_demux_reg_pkg
`default_nettype wire

// File: rtl/param_1x2_demux_reg_hs_slot.sv
`default_nettype none
// ============================================================================
// Module   : hs_slot_reg
// Brief    : One-entry valid/ready holding register with a drain counter.
// Revision : 1.0
// ============================================================================
module hs_slot_reg
  import param_1x2_demux_reg_pkg::*;
#(
  parameter int n     = 32,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [n-1:0]     load_data,
  output logic             slot_ready,
  output logic [n-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic             r_valid;
  logic [n-1:0]     r_data;
  logic [CNT_W-1:0] r_count;
  logic             w_drain;

  assign w_drain    = r_valid & out_ready;
  // Slot can take a new word when empty or when its word leaves this cycle.
  assign slot_ready = ~r_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  // Wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_drain) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign count     = r_count;

endmodule : hs_slot_reg
`default_nettype wire

// File: rtl/param_1x2_demux_reg.sv
`default_nettype none
// ============================================================================
// Module   : param_1x2_demux_reg
// Brief    : Registered 1-to-2 valid/ready demultiplexer with transfer counters.
// Revision : 1.0
// ============================================================================
module param_1x2_demux_reg
  import param_1x2_demux_reg_pkg::*;
#(
  parameter int n     = 32,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [n-1:0]     in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [n-1:0]     out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [n-1:0]     out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [CNT_W-1:0] out1_count,
  output logic [CNT_W-1:0] out2_count
);

  logic w_ready1;
  logic w_ready2;
  logic w_accept;
  logic w_load1;
  logic w_load2;

  // Only the selected slot gates acceptance; the other slot may be stalled.
  assign in_ready = (in_sel == SEL_PORT2) ? w_ready2 : w_ready1;
  assign w_accept = in_valid & in_ready;
  assign w_load1  = w_accept & (in_sel == SEL_PORT1);
  assign w_load2  = w_accept & (in_sel == SEL_PORT2);

  hs_slot_reg #(
    .n     (n),
    .CNT_W (CNT_W)
  ) u_slot1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_load1),
    .load_data  (in_data),
    .slot_ready (w_ready1),
    .out_data   (out1_data),
    .out_valid  (out1_valid),
    .out_ready  (out1_ready),
    .count      (out1_count)
  );

  hs_slot_reg #(
    .n     (n),
    .CNT_W (CNT_W)
  ) u_slot2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_load2),
    .load_data  (in_data),
    .slot_ready (w_ready2),
    .out_data   (out2_data),
    .out_valid  (out2_valid),
    .out_ready  (out2_ready),
    .count      (out2_count)
  );

endmodule : param_1x2_demux_reg
`default_nettype wire
